// File: rtl/pipe_decode.sv
// pipe_decode: registered, valid/ready handshaked instruction-decode stage.
// Slices the instruction into its fields, builds the XLEN-wide immediate, classifies
// the format and flags illegal opcodes. The result is held in a pipeline register
// between fetch and execute. The stage supports stall (back-pressure) and flush.
//
// Optional feature: define DECODE_SKID_EN to add a 2-entry skid buffer. in_ready then
// comes from a register and has no combinational path from out_ready. When the macro
// is undefined, the stage is one pipeline register with a combinational in_ready.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               synchronous kill of stage contents (branch redirect)
//   in_valid/in_ready   fetch-side handshake; in_instr, in_pc sampled on transfer
//   out_valid/out_ready execute-side handshake
//   out_pc, out_opcode, out_func3, out_func7, out_rd, out_rs1, out_rs2
//                       registered instruction fields
//   out_imm             generated immediate (XLEN bits)
//   out_fmt             0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_rd_we, out_rs1_used, out_rs2_used, out_illegal
//                       register-usage and legality flags
module pipe_decode #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REGNUM_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [ADDR_W-1:0]   in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_func3,
    output logic [6:0]          out_func7,
    output logic [REGNUM_W-1:0] out_rd,
    output logic [REGNUM_W-1:0] out_rs1,
    output logic [REGNUM_W-1:0] out_rs2,
    output logic [XLEN-1:0]     out_imm,
    output logic [2:0]          out_fmt,
    output logic                out_rd_we,
    output logic                out_rs1_used,
    output logic                out_rs2_used,
    output logic                out_illegal
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned FMT_W = 3;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
    localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic [OPC_W-1:0]    opcode;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [REGNUM_W-1:0] rd;
        logic [REGNUM_W-1:0] rs1;
        logic [REGNUM_W-1:0] rs2;
        logic [XLEN-1:0]     imm;
        logic [FMT_W-1:0]    fmt;
        logic                rd_we;
        logic                rs1_used;
        logic                rs2_used;
        logic                illegal;
    } bundle_t;

    // Candidate immediates. A signed operand is sign-extended from instr[31] when it is cast to XLEN.
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_i_zx;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i    = XLEN'($signed(in_instr[31:20]));
    assign imm_i_zx = XLEN'(in_instr[31:20]);
    assign imm_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));

    bundle_t dec;
    logic    rd_nz;

    assign rd_nz = (in_instr[11:7] != 5'd0);

    // Combinational decode of the incoming instruction
    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.opcode   = in_instr[6:0];
        dec.func3    = in_instr[14:12];
        dec.func7    = in_instr[31:25];
        dec.rd       = REGNUM_W'(in_instr[11:7]);
        dec.rs1      = REGNUM_W'(in_instr[19:15]);
        dec.rs2      = REGNUM_W'(in_instr[24:20]);
        case (in_instr[6:0])
            OP_R: begin
                dec.fmt      = FMT_R;
                dec.rd_we    = rd_nz;
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
            end
            OP_IMM: begin
                dec.fmt      = FMT_I;
                // Shift amounts (slli/srli/srai) carry no sign, so that field is zero-extended
                dec.imm      = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                               ? imm_i_zx : imm_i;
                dec.rd_we    = rd_nz;
                dec.rs1_used = 1'b1;
            end
            OP_LOAD, OP_JALR: begin
                dec.fmt      = FMT_I;
                dec.imm      = imm_i;
                dec.rd_we    = rd_nz;
                dec.rs1_used = 1'b1;
            end
            OP_STORE: begin
                dec.fmt      = FMT_S;
                dec.imm      = imm_s;
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                dec.fmt      = FMT_B;
                dec.imm      = imm_b;
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt      = FMT_U;
                dec.imm      = imm_u;
                dec.rd_we    = rd_nz;
            end
            OP_JAL: begin
                dec.fmt      = FMT_J;
                dec.imm      = imm_j;
                dec.rd_we    = rd_nz;
            end
            default: begin
                dec.fmt      = FMT_ILL;
                dec.illegal  = 1'b1;
            end
        endcase
    end

    bundle_t head_q;
    logic    head_valid_q;
    logic    push;

    assign push = in_valid && in_ready;

`ifdef DECODE_SKID_EN
    bundle_t skid_q;
    bundle_t head_d;
    bundle_t skid_d;
    logic    skid_valid_q;
    logic    head_valid_d;
    logic    skid_valid_d;
    logic    ready_q;
    logic    pop;

    assign pop      = head_valid_q && out_ready;
    // ready_q only records occupancy. Reset and flush still block the input in their own cycle.
    assign in_ready = ready_q && !flush && !reset;

    // Next-state logic for the two-entry buffer. The head entry drives the outputs.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end
        if (push) begin
            if (!head_valid_d) begin
                head_d       = dec;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    // Buffer registers. in_ready is registered and set while at most one entry is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (flush) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !(head_valid_d && skid_valid_d);
        end
    end
`else
    // Accept when the stage is empty or being drained this cycle
    assign in_ready = !reset && !flush && (!head_valid_q || out_ready);

    // Single pipeline register. A new bundle replaces a draining one with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else if (flush) begin
            head_valid_q <= 1'b0;
        end else if (push) begin
            head_q       <= dec;
            head_valid_q <= 1'b1;
        end else if (out_ready) begin
            head_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid    = head_valid_q;
    assign out_pc       = head_q.pc;
    assign out_opcode   = head_q.opcode;
    assign out_func3    = head_q.func3;
    assign out_func7    = head_q.func7;
    assign out_rd       = head_q.rd;
    assign out_rs1      = head_q.rs1;
    assign out_rs2      = head_q.rs2;
    assign out_imm      = head_q.imm;
    assign out_fmt      = head_q.fmt;
    assign out_rd_we    = head_q.rd_we;
    assign out_rs1_used = head_q.rs1_used;
    assign out_rs2_used = head_q.rs2_used;
    assign out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: directed self-checking bench for pipe_decode (XLEN=32).
// It covers reset, streaming decode of every format, back-pressure, flush, and reset
// asserted mid-stall. Expected values are hand-computed constants.
module tb_pipe_decode;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned REGNUM_W = 5;
    localparam int unsigned NVEC     = 11;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [ADDR_W-1:0]   in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_pc;
    logic [6:0]          out_opcode;
    logic [2:0]          out_func3;
    logic [6:0]          out_func7;
    logic [REGNUM_W-1:0] out_rd;
    logic [REGNUM_W-1:0] out_rs1;
    logic [REGNUM_W-1:0] out_rs2;
    logic [XLEN-1:0]     out_imm;
    logic [2:0]          out_fmt;
    logic                out_rd_we;
    logic                out_rs1_used;
    logic                out_rs2_used;
    logic                out_illegal;

    pipe_decode #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REGNUM_W(REGNUM_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic        u1;
        logic        u2;
        logic        ill;
    } vec_t;

    vec_t        tbl [NVEC];
    int          bp_idx [4];
    int          total = 0;
    int          bad   = 0;
    int          sent;
    int          recv;
    logic        stalled;
    logic [31:0] held_pc;
    logic [31:0] held_imm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input logic [31:0] pc);
        chk({tag, ".valid"},  64'(out_valid),    64'(1'b1));
        chk({tag, ".pc"},     64'(out_pc),       64'(pc));
        chk({tag, ".opcode"}, 64'(out_opcode),   64'(v.instr[6:0]));
        chk({tag, ".func3"},  64'(out_func3),    64'(v.instr[14:12]));
        chk({tag, ".func7"},  64'(out_func7),    64'(v.instr[31:25]));
        chk({tag, ".fmt"},    64'(out_fmt),      64'(v.fmt));
        chk({tag, ".imm"},    64'(out_imm),      64'(v.imm));
        chk({tag, ".rd"},     64'(out_rd),       64'(v.rd));
        chk({tag, ".rs1"},    64'(out_rs1),      64'(v.rs1));
        chk({tag, ".rs2"},    64'(out_rs2),      64'(v.rs2));
        chk({tag, ".rd_we"},  64'(out_rd_we),    64'(v.we));
        chk({tag, ".rs1u"},   64'(out_rs1_used), 64'(v.u1));
        chk({tag, ".rs2u"},   64'(out_rs2_used), 64'(v.u2));
        chk({tag, ".ill"},    64'(out_illegal),  64'(v.ill));
    endtask

    initial begin
        //                 instr         fmt   imm            rd     rs1    rs2    we    u1    u2    ill
        tbl[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 5'd1,  5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0}; // addi x1,x0,-1
        tbl[1]  = '{32'h4050D093, 3'd1, 32'h00000405, 5'd1,  5'd1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0}; // srai x1,x1,5
        tbl[2]  = '{32'hFFC15083, 3'd1, 32'hFFFFFFFC, 5'd1,  5'd2, 5'd28, 1'b1, 1'b1, 1'b0, 1'b0}; // lhu x1,-4(x2)
        tbl[3]  = '{32'hFE208CE3, 3'd3, 32'hFFFFFFF8, 5'd25, 5'd1, 5'd2,  1'b0, 1'b1, 1'b1, 1'b0}; // beq x1,x2,-8
        tbl[4]  = '{32'h00000000, 3'd7, 32'h00000000, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1}; // illegal
        tbl[5]  = '{32'h800000B7, 3'd4, 32'h80000000, 5'd1,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0}; // lui x1,0x80000
        tbl[6]  = '{32'h008000EF, 3'd5, 32'h00000008, 5'd1,  5'd0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,8
        tbl[7]  = '{32'h002081B3, 3'd0, 32'h00000000, 5'd3,  5'd1, 5'd2,  1'b1, 1'b1, 1'b1, 1'b0}; // add x3,x1,x2
        tbl[8]  = '{32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 5'd28, 5'd1, 5'd2,  1'b0, 1'b1, 1'b1, 1'b0}; // sw x2,-4(x1)
        tbl[9]  = '{32'h00000013, 3'd1, 32'h00000000, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0}; // nop, rd=x0
        tbl[10] = '{32'hFFF09093, 3'd1, 32'h00000FFF, 5'd1,  5'd1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0}; // slli, zero-ext
        bp_idx  = '{0, 1, 3, 5};

        // Reset state
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_pc",    64'(out_pc),    64'(0));
        chk("rst_imm",   64'(out_imm),   64'(0));
        chk("rst_fmt",   64'(out_fmt),   64'(0));
        reset = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Full-throughput stream with out_ready held high; 1-cycle latency
        for (int i = 0; i <= int'(NVEC); i++) begin
            @(negedge clk);
            if (i > 0) check_vec($sformatf("stream%0d", i - 1), tbl[i - 1], 32'h1000 + 32'(4 * (i - 1)));
            if (i < int'(NVEC)) begin
                in_valid = 1'b1;
                in_instr = tbl[i].instr;
                in_pc    = 32'h1000 + 32'(4 * i);
                #1 chk("stream_in_ready", 64'(in_ready), 64'(1));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_drained", 64'(out_valid), 64'(0));

        // Back-pressure: out_ready low for 3 cycles mid-stream
        sent = 0;
        recv = 0;
        stalled = 1'b0;
        held_pc = '0;
        held_imm = '0;
        for (int c = 0; c < 30 && recv < 4; c++) begin
            @(negedge clk);
            if (stalled) begin
                chk("bp_hold_valid", 64'(out_valid), 64'(1));
                chk("bp_hold_pc",    64'(out_pc),    64'(held_pc));
                chk("bp_hold_imm",   64'(out_imm),   64'(held_imm));
            end
            out_ready = !(c >= 3 && c <= 5);
            if (sent < 4) begin
                in_valid = 1'b1;
                in_instr = tbl[bp_idx[sent]].instr;
                in_pc    = 32'h2000 + 32'(4 * sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                chk("bp_order_pc",  64'(out_pc),  64'(32'h2000 + 32'(4 * recv)));
                chk("bp_order_imm", 64'(out_imm), 64'(tbl[bp_idx[recv]].imm));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stalled  = out_valid && !out_ready;
            held_pc  = out_pc;
            held_imm = out_imm;
        end
        chk("bp_count", 64'(recv), 64'(4));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_dup", 64'(out_valid), 64'(0));

        // Stall with occupancy: in_ready drop point depends on the skid buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = tbl[7].instr;
        in_pc     = 32'h3000;
        @(negedge clk);
        check_vec("stall_a", tbl[7], 32'h3000);
        in_instr = tbl[6].instr;
        in_pc    = 32'h3004;
`ifdef DECODE_SKID_EN
        #1 chk("stall_ready_1entry", 64'(in_ready), 64'(1));
`else
        #1 chk("stall_ready_full", 64'(in_ready), 64'(0));
`endif
        @(negedge clk);
        chk("stall_a_hold_pc", 64'(out_pc), 64'(32'h3000));
        #1 chk("stall_ready_2entry", 64'(in_ready), 64'(0));

        // Flush while stalled with in_valid high
        flush    = 1'b1;
        in_instr = tbl[8].instr;
        in_pc    = 32'h3008;
        #1 chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'(0));
        flush     = 1'b0;
        out_ready = 1'b1;
        in_instr  = tbl[3].instr;
        in_pc     = 32'h300C;
        #1 chk("post_flush_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        check_vec("post_flush", tbl[3], 32'h300C);
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_discard", 64'(out_valid), 64'(0));

        // Reset asserted mid-stall clears the bundle registers
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = tbl[0].instr;
        in_pc     = 32'h4000;
        @(negedge clk);
        chk("rst_stall_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_pc",    64'(out_pc),    64'(0));
        chk("rst_mid_imm",   64'(out_imm),   64'(0));
        chk("rst_mid_rd",    64'(out_rd),    64'(0));
        #1 chk("rst_mid_ready", 64'(in_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
